n_any_gate_bist: RTL
====================

// Module: n_any_gate_bist
// PURPOSE
//  Hardware self-test driver/checker for the N-input selectable gate (AND/XOR/XNOR/OR).
//  Drives gate_in/gate_select from an LFSR and samples the gate's combinational gate_out.
//  Compares gate_out against an internal golden model and reports pass/fail counts.
//  Sits beside the gate in the datapath and replaces the simulation-only self-test with
//  synthesizable on-chip checking.
// PARAMETERS
//  N            2          gate input width; legal range 1..14
//  NUM_VECTORS  10         vectors applied per run; legal range 1..2**CNT_W-1
//  CNT_W        8          width of vector, pass and fail counters
//  LFSR_SEED    16'hACE1   LFSR load value at start; 0 is replaced by 16'h0001
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  start        in   1      single-cycle request to begin a run; sampled only in IDLE/DONE
//  gate_in      out  N      stimulus to the gate under test (registered)
//  gate_select  out  2      00 AND, 01 XOR, 10 XNOR, 11 OR (registered)
//  gate_out     in   1      gate under test response (combinational from gate_in/select)
//  busy         out  1      high from the cycle after start is accepted until DONE
//  done         out  1      high in DONE; held until the next accepted start or rst
//  pass         out  1      done && fail_count==0
//  pass_count   out  CNT_W  vectors matched, saturating
//  fail_count   out  CNT_W  vectors mismatched, saturating
//  first_fail   out  N+2    {gate_select,gate_in} of the first mismatch; 0 if none
// BEHAVIOUR
//  Reset: state=IDLE; gate_in, gate_select, counters and first_fail=0; busy, done and pass=0; LFSR=seed.
//  FSM IDLE -start-> LOAD -> CHECK -(vec_cnt<NUM_VECTORS)-> LOAD | -(==NUM_VECTORS)-> DONE -start-> LOAD.
//  Accepting start from IDLE or DONE clears the counters, first_fail and done and reloads the LFSR from seed.
//  LOAD: register gate_in=lfsr[N-1:0] and gate_select=lfsr[15:14]; latch expected from the same bits.
//  CHECK: compare gate_out with expected; increment pass_count or fail_count.
//    CHECK also advances the LFSR and increments vec_cnt.
//  Latency: exactly 2 cycles per vector; done rises 2*NUM_VECTORS+1 cycles after the start cycle.
//  Golden model: AND=&in, XOR=^in, XNOR=~^in, OR=|in over the N stimulus bits.
//  LFSR: 16-bit Galois, right-shift, mask 16'hB400. It advances only in CHECK.
//  Runs are deterministic: the same seed gives the same vector sequence.
//  first_fail is written only on the first mismatch of a run; later mismatches do not change it.
//  Counters saturate at 2**CNT_W-1 with no wrap. vec_cnt is internal and cannot saturate (NUM_VECTORS is limited).
//  start while busy is ignored with no restart. start and rst in the same cycle: rst wins.
//  rst during a run: immediate return to the reset state; no partial result is kept.
//  gate_in and gate_select hold their last values in DONE and IDLE.
// STRUCTURE
//  Shared package n_any_gate_pkg holds:
//    GATE_AND/GATE_XOR/GATE_XNOR/GATE_OR 2-bit select constants;
//    bist_state_t {IDLE,LOAD,CHECK,DONE};
//    function gate_model(in,sel), which the gate RTL and its benches reuse.
//  Sub-module bist_lfsr16 (clk, rst, load, seed, advance, q[15:0]) holds the 0-seed substitution.
//  The top level contains the FSM, the golden model, the counters and the capture register.
// TESTING
//  1 rst, then start with N=2 and seed ACE1: first LOAD drives gate_in=2'b01, gate_select=2'b10, expected=0.
//  2 Correct gate, NUM_VECTORS=10: done at start+21 cycles; pass_count=10, fail_count=0, pass=1.
//  3 gate_out stuck-at-0: fail_count = number of vectors with expected 1; pass=0.
//    first_fail = {sel,in} of the first such vector.
//  4 rst asserted in the CHECK of vector 5: all outputs 0 and state IDLE next cycle.
//    A new start reproduces the case-1 vector sequence.
//  5 start pulsed every cycle while busy: no restart; counts as in case 2. start in DONE launches a fresh run.
//  6 CNT_W=4, NUM_VECTORS=15, gate_out inverted: fail_count=15 with no wrap.
//    Rerun with NUM_VECTORS=15, CNT_W=4, stuck fault: no counter exceeds 15.

Source files
------------

// File: rtl/n_any_gate_pkg.sv
// Shared definitions for the selectable N-input gate and its on-chip self-test:
// select encodings, BIST FSM states and the reference gate function.
package n_any_gate_pkg;

   localparam logic [1:0] GATE_AND  = 2'b00;
   localparam logic [1:0] GATE_XOR  = 2'b01;
   localparam logic [1:0] GATE_XNOR = 2'b10;
   localparam logic [1:0] GATE_OR   = 2'b11;

   localparam int unsigned MAX_N = 14;

   typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} bist_state_t;

   // Only the low n bits of in take part; the rest are ignored so AND is not forced low.
   function automatic logic gate_model(input logic [MAX_N-1:0] in, input logic [1:0] sel,
                                       input int unsigned n);
      logic r_and;
      logic r_xor;
      logic r_or;
      r_and = 1'b1;
      r_xor = 1'b0;
      r_or  = 1'b0;
      for (int unsigned i = 0; i < MAX_N; i++) begin
         if (i < n) begin
            r_and = r_and & in[i];
            r_xor = r_xor ^ in[i];
            r_or  = r_or | in[i];
         end
      end
      case (sel)
         GATE_AND:  gate_model = r_and;
         GATE_XOR:  gate_model = r_xor;
         GATE_XNOR: gate_model = ~r_xor;
         default:   gate_model = r_or;
      endcase
   endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// 16-bit right-shifting Galois LFSR (mask 16'hB400) used as the BIST stimulus source.
// A zero seed would lock the register, so it is replaced by 16'h0001.
module bist_lfsr16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        advance,
   output logic [15:0] q
);

   localparam logic [15:0] Mask = 16'hB400;

   logic [15:0] seed_fix;
   logic [15:0] q_d;
   logic [15:0] q_q;

   always_comb begin
      seed_fix = (seed == 16'h0000) ? 16'h0001 : seed;
      q_d      = q_q;
      if (load) begin
         q_d = seed_fix;
      end else if (advance) begin
         q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? Mask : 16'h0000);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= seed_fix;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/n_any_gate_bist.sv
// Self-test driver/checker for the N-input selectable gate: LFSR stimulus, golden-model
// comparison and saturating pass/fail counters, two cycles per vector.
module n_any_gate_bist
   import n_any_gate_pkg::*;
#(
   parameter int unsigned N           = 2,
   parameter int unsigned NUM_VECTORS = 10,
   parameter int unsigned CNT_W       = 8,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [N-1:0]     gate_in,
   output logic [1:0]       gate_select,
   input  logic             gate_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] fail_count,
   output logic [N+1:0]     first_fail
);

   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] NumVec = CNT_W'(NUM_VECTORS);

   bist_state_t      state_d, state_q;
   logic [N-1:0]     gate_in_d, gate_in_q;
   logic [1:0]       sel_d, sel_q;
   logic             exp_d, exp_q;
   logic [CNT_W-1:0] vec_cnt_d, vec_cnt_q;
   logic [CNT_W-1:0] pass_cnt_d, pass_cnt_q;
   logic [CNT_W-1:0] fail_cnt_d, fail_cnt_q;
   logic [N+1:0]     first_fail_d, first_fail_q;

   logic             lfsr_load;
   logic             lfsr_adv;
   logic [15:0]      lfsr_q;
   logic [MAX_N-1:0] lfsr_in;
   logic             unused_lfsr;

   bist_lfsr16 u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load    (lfsr_load),
      .seed    (LFSR_SEED),
      .advance (lfsr_adv),
      .q       (lfsr_q)
   );

   // Bits between the stimulus slice and the select field only feed the LFSR itself.
   assign unused_lfsr = ^lfsr_q;

   always_comb begin
      state_d      = state_q;
      gate_in_d    = gate_in_q;
      sel_d        = sel_q;
      exp_d        = exp_q;
      vec_cnt_d    = vec_cnt_q;
      pass_cnt_d   = pass_cnt_q;
      fail_cnt_d   = fail_cnt_q;
      first_fail_d = first_fail_q;
      lfsr_load    = 1'b0;
      lfsr_adv     = 1'b0;
      lfsr_in      = '0;
      lfsr_in[N-1:0] = lfsr_q[N-1:0];

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d      = LOAD;
               vec_cnt_d    = '0;
               pass_cnt_d   = '0;
               fail_cnt_d   = '0;
               first_fail_d = '0;
               lfsr_load    = 1'b1;
            end
         end
         LOAD: begin
            gate_in_d = lfsr_q[N-1:0];
            sel_d     = lfsr_q[15:14];
            exp_d     = gate_model(lfsr_in, lfsr_q[15:14], N);
            state_d   = CHECK;
         end
         CHECK: begin
            lfsr_adv  = 1'b1;
            vec_cnt_d = vec_cnt_q + 1'b1;
            if (gate_out != exp_q) begin
               // A zero fail count means no mismatch has been seen yet in this run.
               if (fail_cnt_q == '0) first_fail_d = {sel_q, gate_in_q};
               if (fail_cnt_q != CntMax) fail_cnt_d = fail_cnt_q + 1'b1;
            end else if (pass_cnt_q != CntMax) begin
               pass_cnt_d = pass_cnt_q + 1'b1;
            end
            state_d = (vec_cnt_d == NumVec) ? DONE : LOAD;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         gate_in_q    <= '0;
         sel_q        <= '0;
         exp_q        <= 1'b0;
         vec_cnt_q    <= '0;
         pass_cnt_q   <= '0;
         fail_cnt_q   <= '0;
         first_fail_q <= '0;
      end else begin
         state_q      <= state_d;
         gate_in_q    <= gate_in_d;
         sel_q        <= sel_d;
         exp_q        <= exp_d;
         vec_cnt_q    <= vec_cnt_d;
         pass_cnt_q   <= pass_cnt_d;
         fail_cnt_q   <= fail_cnt_d;
         first_fail_q <= first_fail_d;
      end
   end

   assign gate_in     = gate_in_q;
   assign gate_select = sel_q;
   assign busy        = (state_q == LOAD) || (state_q == CHECK);
   assign done        = (state_q == DONE);
   assign pass        = done && (fail_cnt_q == '0);
   assign pass_count  = pass_cnt_q;
   assign fail_count  = fail_cnt_q;
   assign first_fail  = first_fail_q;

endmodule
